// File: rtl/pdc_ram_mp.sv
// Multi-read-port, single-write-port synchronous RAM with write-first forwarding
// and a built-in clear engine that fills the array with INIT_VAL after reset or on request.
module pdc_ram_mp #(
  parameter int               WIDTH    = 40,
  parameter int               AW       = 11,
  parameter int               NREAD    = 3,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    read_addr,
  input  logic [NREAD-1:0]       read_clkEn,
  output logic [NREAD*WIDTH-1:0] read_data,
  input  logic [AW-1:0]          write_addr,
  input  logic [WIDTH-1:0]       write_data,
  input  logic                   write_wen,
  input  logic                   clear,
  output logic                   init_busy
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] ram [DEPTH];

  logic             busy;
  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The clear sweep ends on the last address, not on counter wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == {AW{1'b1}}) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (clear) begin
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  assign busy      = (state_q == ST_CLEAR);
  assign init_busy = busy;

  // The clear engine owns the single write port while busy; reset itself never writes.
  assign mem_we = !rst && (busy || write_wen);
  assign mem_wa = busy ? cnt_q : write_addr;
  assign mem_wd = busy ? INIT_VAL : write_data;

  always_ff @(posedge clk) begin
    if (mem_we) ram[mem_wa] <= mem_wd;
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        addr_q  <= '0;
        rdata_q <= '0;
      end else begin
        if (read_clkEn[k]) addr_q <= read_addr[k*AW +: AW];
        if (busy)
          rdata_q <= INIT_VAL;
        else if (write_wen && (write_addr == addr_q))
          rdata_q <= write_data;
        else
          rdata_q <= ram[addr_q];
      end
    end

    assign read_data[k*WIDTH +: WIDTH] = rdata_q;
  end

endmodule

// File: tb/tb_pdc_ram_mp.sv
// Randomized and directed bench for pdc_ram_mp against an array-level reference model.
module tb_pdc_ram_mp;
  localparam int W     = 40;
  localparam int AW    = 11;
  localparam int NR    = 3;
  localparam int DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR*AW-1:0]  read_addr = '0;
  logic [NR-1:0]     read_clkEn = '0;
  logic [NR*W-1:0]   read_data;
  logic [AW-1:0]     write_addr = '0;
  logic [W-1:0]      write_data = '0;
  logic              write_wen = 1'b0;
  logic              clear = 1'b0;
  logic              init_busy;

  pdc_ram_mp #(.WIDTH(W), .AW(AW), .NREAD(NR), .INIT_VAL('0)) dut (
    .clk       (clk),
    .rst       (rst),
    .read_addr (read_addr),
    .read_clkEn(read_clkEn),
    .read_data (read_data),
    .write_addr(write_addr),
    .write_data(write_data),
    .write_wen (write_wen),
    .clear     (clear),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  // Reference model: memory contents, per-port held address, expected outputs,
  // and the number of clear edges still owed.
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] maddr [NR];
  logic [W-1:0]  exp_rd [NR];
  int            clear_left;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] port_rd(input int k);
    return read_data[k*W +: W];
  endfunction

  task automatic set_port(input int k, input logic [AW-1:0] a, input logic en);
    read_addr[k*AW +: AW] = a;
    read_clkEn[k]         = en;
  endtask

  task automatic idle_inputs();
    read_clkEn = '0;
    write_wen  = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic tick();
    bit busy_now;
    busy_now = (clear_left > 0);
    for (int k = 0; k < NR; k++) begin
      if (busy_now)
        exp_rd[k] = '0;
      else if (write_wen && write_addr == maddr[k])
        exp_rd[k] = write_data;
      else
        exp_rd[k] = mem[maddr[k]];
      if (read_clkEn[k]) maddr[k] = read_addr[k*AW +: AW];
    end
    if (busy_now) begin
      clear_left--;
      if (clear_left == 0)
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end else begin
      if (write_wen) mem[write_addr] = write_data;
      if (clear) clear_left = DEPTH;
    end
    @(posedge clk);
    #1;
    check("init_busy", 64'(init_busy), 64'(clear_left > 0));
    for (int k = 0; k < NR; k++)
      check($sformatf("rd%0d", k), 64'(port_rd(k)), 64'(exp_rd[k]));
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    clear_left = DEPTH;
    for (int k = 0; k < NR; k++) begin
      maddr[k]  = '0;
      exp_rd[k] = '0;
    end
    #1;
    check("rst_busy", 64'(init_busy), 64'(1));
    for (int k = 0; k < NR; k++)
      check($sformatf("rst_rd%0d", k), 64'(port_rd(k)), 64'(0));
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (init_busy && n < 3000);
    check(tag, 64'(n), 64'(DEPTH));
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [W-1:0] d);
    write_addr = a;
    write_data = d;
    write_wen  = 1'b1;
  endtask

  initial begin
    logic [63:0] r;
    int clears;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    #2;

    // 1: reset and full clear sweep, then reads of corner addresses
    apply_reset(3);
    count_busy("clear_len_reset");
    set_port(0, 11'd0, 1'b1); set_port(1, 11'd1234, 1'b1); set_port(2, 11'd2047, 1'b1);
    tick(); idle_inputs(); tick();
    for (int k = 0; k < NR; k++) check($sformatf("t1_rd%0d", k), 64'(port_rd(k)), 64'(0));

    // 2: write then read back with two-edge latency
    write(11'd5, 40'h00ABCDEF12); tick(); idle_inputs();
    set_port(0, 11'd5, 1'b1); tick(); idle_inputs(); tick();
    check("t2_rd0", 64'(port_rd(0)), 64'h00ABCDEF12);

    // 3: forwarding on a held address
    write(11'd7, 40'h11); set_port(1, 11'd7, 1'b1); tick(); idle_inputs();
    tick(); check("t3_old", 64'(port_rd(1)), 64'h11);
    write(11'd7, 40'h22); tick(); idle_inputs();
    check("t3_fwd", 64'(port_rd(1)), 64'h22);

    // 4: hold keeps address 9 even though read_addr moves to 10
    write(11'd10, 40'h44); set_port(2, 11'd9, 1'b1); tick(); idle_inputs();
    set_port(2, 11'd10, 1'b0); tick();
    write(11'd9, 40'h33); tick(); idle_inputs(); tick();
    check("t4_hold", 64'(port_rd(2)), 64'h33);

    // 5: clear with a simultaneous write; writes during busy are dropped
    write(11'd3, 40'h55); clear = 1'b1; tick(); idle_inputs();
    check("t5_busy", 64'(init_busy), 64'(1));
    write(11'd3, 40'h77);
    count_busy("clear_len_req");
    idle_inputs();
    set_port(0, 11'd3, 1'b1); set_port(1, 11'd5, 1'b1); tick(); idle_inputs(); tick();
    check("t5_addr3", 64'(port_rd(0)), 64'(0));
    check("t5_addr5", 64'(port_rd(1)), 64'(0));

    // 6: reset in the middle of a clear restarts the full sweep
    clear = 1'b1; tick(); idle_inputs();
    repeat (100) tick();
    apply_reset(2);
    count_busy("clear_len_midrst");

    // Randomized traffic with address collisions and occasional clears
    clears = 0;
    for (int it = 0; it < 2000; it++) begin
      r = {$urandom(), $urandom()};
      write_data = r[W-1:0];
      write_addr = AW'($urandom_range(0, 15));
      write_wen  = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < NR; k++)
        set_port(k, ($urandom_range(0, 7) == 0) ? AW'($urandom()) : AW'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
      clear = 1'b0;
      if (clears < 2 && $urandom_range(0, 999) == 0) begin
        clear = 1'b1;
        clears++;
      end
      tick();
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
